// File: rtl/mips_lite_pkg.sv
// mips_lite_pkg: state encodings, opcodes and control bundle for the multicycle controller
package mips_lite_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ_EX   = 4'd8,
    S_J_EX     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic [1:0] aluop;
    logic       instr_done;
  } ctrl_t;
  // Unsupported opcodes fall back to FETCH, which is also how they are detected
  function automatic state_t decode_next(logic [5:0] op);
    case (op)
      OP_LW, OP_SW: return S_MEMADR;
      OP_RTYPE:     return S_RTYPE_EX;
      OP_BEQ:       return S_BEQ_EX;
      OP_J:         return S_J_EX;
      OP_ADDI:      return S_ADDI_EX;
      default:      return S_FETCH;
    endcase
  endfunction
endpackage

// File: rtl/mc_outdec.sv
// mc_outdec: Moore decode of the controller state into datapath controls
module mc_outdec
  import mips_lite_pkg::*;
(
  input  state_t st,
  output ctrl_t  c
);
  always_comb begin
    c = '0;
    case (st)
      S_FETCH: begin
        c.memread = 1'b1;
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
        c.alusrcb = 2'b01;
      end
      S_DECODE: c.alusrcb = 2'b11;
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.regwrite   = 1'b1;
        c.memtoreg   = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEMWR: begin
        c.memwrite   = 1'b1;
        c.iord       = 1'b1;
        c.instr_done = 1'b1;
      end
      S_RTYPE_EX: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      S_RTYPE_WB: begin
        c.regwrite   = 1'b1;
        c.regdst     = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BEQ_EX: begin
        c.alusrca     = 1'b1;
        c.aluop       = 2'b01;
        c.pcwritecond = 1'b1;
        c.pcsource    = 2'b01;
        c.instr_done  = 1'b1;
      end
      S_J_EX: begin
        c.pcwrite    = 1'b1;
        c.pcsource   = 2'b10;
        c.instr_done = 1'b1;
      end
      S_ADDI_EX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_ADDI_WB: begin
        c.regwrite   = 1'b1;
        c.instr_done = 1'b1;
      end
      default: c = '0;
    endcase
  end
endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle MIPS-lite control FSM with sticky illegal-opcode flag
module mc_control
  import mips_lite_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       memtoreg,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsource,
  output logic       aluop1,
  output logic       aluop0,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);
  state_t st, nst;
  ctrl_t  c;
  logic   ill;
  always_ff @(posedge clk) begin
    if (reset) begin
      st  <= S_FETCH;
      ill <= 1'b0;
    end else begin
      st  <= nst;
      ill <= ill | (st == S_DECODE && decode_next(op) == S_FETCH);
    end
  end
  always_comb begin
    nst = S_FETCH;
    case (st)
      S_FETCH:    nst = S_DECODE;
      S_DECODE:   nst = decode_next(op);
      S_MEMADR:   nst = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    nst = S_MEMWB;
      S_RTYPE_EX: nst = S_RTYPE_WB;
      S_ADDI_EX:  nst = S_ADDI_WB;
      default:    nst = S_FETCH;
    endcase
  end
  mc_outdec u_outdec (
    .st(st),
    .c (c)
  );
  assign pcwrite     = c.pcwrite;
  assign pcwritecond = c.pcwritecond;
  assign iord        = c.iord;
  assign memread     = c.memread;
  assign memwrite    = c.memwrite;
  assign memtoreg    = c.memtoreg;
  assign irwrite     = c.irwrite;
  assign regwrite    = c.regwrite;
  assign regdst      = c.regdst;
  assign alusrca     = c.alusrca;
  assign alusrcb     = c.alusrcb;
  assign pcsource    = c.pcsource;
  assign aluop1      = c.aluop[1];
  assign aluop0      = c.aluop[0];
  assign instr_done  = c.instr_done;
  assign illegal_op  = ill;
  assign state       = st;
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: scoreboard bench for mc_control driven by directed and random opcode streams
`timescale 1ns/1ps
module tb_mc_control;
  logic clk = 1'b0, reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite, regwrite, regdst, alusrca;
  logic [1:0] alusrcb, pcsource;
  logic aluop1, aluop0, instr_done, illegal_op;
  logic [3:0] state;

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] o;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;
  int done_seen = 0, done_exp = 0;
  logic ill_exp = 1'b0;

  always #5 clk = ~clk;

  mc_control dut (
    .clk(clk), .reset(reset), .op(op),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
    .memwrite(memwrite), .memtoreg(memtoreg), .irwrite(irwrite), .regwrite(regwrite),
    .regdst(regdst), .alusrca(alusrca), .alusrcb(alusrcb), .pcsource(pcsource),
    .aluop1(aluop1), .aluop0(aluop0), .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state)
  );

  // Hand-written control table, one row per state code
  function automatic logic [16:0] exp_out(int s);
    logic pw = 0, pwc = 0, io = 0, mr = 0, mw = 0, m2r = 0, irw = 0, rw = 0, rd = 0, asa = 0, dn = 0;
    logic [1:0] asb = 0, pcs = 0, aop = 0;
    case (s)
      0:  begin pw = 1; mr = 1; irw = 1; asb = 2'b01; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; dn = 1; end
      5:  begin mw = 1; io = 1; dn = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; dn = 1; end
      8:  begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; dn = 1; end
      9:  begin pw = 1; pcs = 2'b10; dn = 1; end
      10: begin asa = 1; asb = 2'b10; end
      11: begin rw = 1; dn = 1; end
      default: ;
    endcase
    return {pw, pwc, io, mr, mw, m2r, irw, rw, rd, asa, asb, pcs, aop, dn};
  endfunction

  function automatic bit is_legal(logic [5:0] o);
    return o == 6'b100011 || o == 6'b101011 || o == 6'b000000 ||
           o == 6'b000100 || o == 6'b000010 || o == 6'b001000;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Drive one cycle at the falling edge; queue what the DUT must show after the next rising edge
  task automatic cycle(logic r, logic [5:0] o, int es);
    @(negedge clk);
    reset = r;
    op = o;
    q.push_back({4'(es), exp_out(es), ill_exp});
  endtask

  task automatic do_reset();
    ill_exp = 1'b0;
    cycle(1'b1, 6'($urandom), 0);
  endtask

  // Runs one instruction from FETCH; op is scrambled outside DECODE/MEMADR since it must be ignored there
  task automatic run(logic [5:0] o);
    int seq[$];
    int cur = 0;
    case (o)
      6'b100011: seq = '{1, 2, 3, 4, 0};
      6'b101011: seq = '{1, 2, 5, 0};
      6'b000000: seq = '{1, 6, 7, 0};
      6'b000100: seq = '{1, 8, 0};
      6'b000010: seq = '{1, 9, 0};
      6'b001000: seq = '{1, 10, 11, 0};
      default:   seq = '{1, 0};
    endcase
    foreach (seq[i]) begin
      if (cur == 1 && !is_legal(o)) ill_exp = 1'b1;
      cycle(1'b0, (cur == 1 || cur == 2) ? o : 6'($urandom), seq[i]);
      cur = seq[i];
    end
    if (is_legal(o)) done_exp++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("state", 32'(state), 32'(e.st));
        check("outputs", 32'({pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite,
                               regwrite, regdst, alusrca, alusrcb, pcsource, aluop1, aluop0,
                               instr_done}), 32'(e.o));
        check("illegal_op", 32'(illegal_op), 32'(e.ill));
        if (aluop1 && aluop0) begin
          checks++; errors++;
          $display("FAIL aluop11 got 11 want not 11 at %0t", $time);
        end
        if (state > 4'd11) begin
          checks++; errors++;
          $display("FAIL state_range got %0d want 0..11 at %0t", state, $time);
        end
        if (instr_done) done_seen++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] legal_ops[6];
    legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
    do_reset();
    do_reset();
    run(6'b100011);
    run(6'b000000);
    run(6'b000100);
    run(6'b000010);
    run(6'b001000);
    run(6'b101011);
    run(6'b111111);
    run(6'b100011);
    // SW abandoned by reset while in MEMADR: no memwrite, no instr_done, flag cleared
    cycle(1'b0, 6'b101011, 1);
    cycle(1'b0, 6'b101011, 2);
    do_reset();
    run(6'b101011);
    for (int i = 0; i < 1000; i++)
      run(($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 5)]);
    do_reset();
    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", 32'(q.size()), 32'd0);
    check("instr_done_count", 32'(done_seen), 32'(done_exp));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
